draw_terrain: RTL and testbench

Parametrised terrain renderer for the VGA pipeline. It draws a screen frame plus up to `N_OBST` outlined rectangular obstacles over the incoming pixel stream. Obstacles live in a run-time writable table, double-buffered and committed only at vertical blanking, so changes never tear mid-frame. It sits between the timing generator and the sprite/rect drawers, in the slot the fixed-map background drawer used to occupy.

---
 rtl/draw_terrain.sv | 221 ++++++++++++++++++++++
 tb/tb_draw_terrain.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_terrain.sv
// draw_terrain: draws a screen frame plus up to N_OBST outlined rectangular obstacles over
// the VGA pixel stream. Obstacles live in a run-time writable shadow table. That table is
// copied into the active (rendering) table only at a vblank rising edge, so a frame never
// shows a half-updated map.
//
// Optional build macro: TERRAIN_FILL_EN draws obstacle interiors in FILL_RGB. Without it the
// interior hit logic is not built, and interiors show BG_RGB.
//
// Ports:
//   clk, rst               pixel clock, asynchronous active-low reset
//   bg_in_*_i              incoming timing (hcount/vcount 11 b, sync and blank flags). The
//                          incoming rgb is replaced entirely, so only timing is taken in.
//   bg_out_*_o             timing delayed by 2 cycles, plus the drawn rgb
//   wr_en_i .. wr_y2_i     one-cycle write of {valid, x1, y1, x2, y2} into shadow slot wr_idx_i
//   commit_req_i           pulse requesting a shadow-to-active copy at the next vblank edge
//   commit_pending_o       high from the request until the copy completes
module draw_terrain #(
  parameter int unsigned N_OBST     = 16,
  parameter int unsigned IDX_W      = 6,
  parameter int unsigned BORDER_T   = 5,
  parameter int unsigned FRAME_T    = 1,
  parameter logic [11:0] WALL_RGB   = 12'h0_0_F,
`ifdef TERRAIN_FILL_EN
  parameter logic [11:0] FILL_RGB   = 12'h0_0_4,
`endif
  parameter logic [11:0] BG_RGB     = 12'h0_0_0,
  parameter int unsigned HOR_PIXELS = 1024,
  parameter int unsigned VER_PIXELS = 768
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      bg_in_hcount_i,
  input  logic [10:0]      bg_in_vcount_i,
  input  logic             bg_in_hsync_i,
  input  logic             bg_in_vsync_i,
  input  logic             bg_in_hblnk_i,
  input  logic             bg_in_vblnk_i,
  output logic [10:0]      bg_out_hcount_o,
  output logic [10:0]      bg_out_vcount_o,
  output logic             bg_out_hsync_o,
  output logic             bg_out_vsync_o,
  output logic             bg_out_hblnk_o,
  output logic             bg_out_vblnk_o,
  output logic [11:0]      bg_out_rgb_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_valid_i,
  input  logic [10:0]      wr_x1_i,
  input  logic [10:0]      wr_y1_i,
  input  logic [10:0]      wr_x2_i,
  input  logic [10:0]      wr_y2_i,
  input  logic             commit_req_i,
  output logic             commit_pending_o
);

  typedef struct packed {
    logic        valid;
    logic [10:0] x1;
    logic [10:0] y1;
    logic [10:0] x2;
    logic [10:0] y2;
  } slot_t;

  localparam logic [11:0] BorderT = 12'(BORDER_T);
  localparam logic [11:0] FrameT  = 12'(FRAME_T);
  localparam logic [11:0] HorLim  = 12'(HOR_PIXELS - FRAME_T);
  localparam logic [11:0] VerLim  = 12'(VER_PIXELS - FRAME_T);

  // Sums are done at 12 bits so x1+T and h+T cannot wrap.
  function automatic logic slot_outer(slot_t s, logic [11:0] h, logic [11:0] v);
    return s.valid && ({1'b0, s.x1} <= h) && (h <= {1'b0, s.x2}) &&
           ({1'b0, s.y1} <= v) && (v <= {1'b0, s.y2});
  endfunction

  function automatic logic slot_inner(slot_t s, logic [11:0] h, logic [11:0] v);
    return ({1'b0, s.x1} + BorderT <= h) && (h + BorderT <= {1'b0, s.x2}) &&
           ({1'b0, s.y1} + BorderT <= v) && (v + BorderT <= {1'b0, s.y2});
  endfunction

  // ---------------------------------------------------------------------------------------
  // Obstacle tables and commit control
  // ---------------------------------------------------------------------------------------
  slot_t shadow_q [N_OBST];
  slot_t active_q [N_OBST];
  logic  pending_q, pending_d;
  logic  vblnk_prev_q;
  logic  wr_ok, do_commit;
  slot_t wr_slot;

  assign wr_ok     = wr_en_i && (32'(wr_idx_i) < N_OBST);
  assign do_commit = bg_in_vblnk_i && !vblnk_prev_q && pending_q;
  assign wr_slot   = '{valid: wr_valid_i, x1: wr_x1_i, y1: wr_y1_i, x2: wr_x2_i, y2: wr_y2_i};

  // A write or request landing on the commit edge misses this copy, so it re-arms pending.
  always_comb begin
    pending_d = pending_q || commit_req_i;
    if (do_commit) pending_d = commit_req_i || wr_ok;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N_OBST; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      pending_q    <= 1'b0;
      vblnk_prev_q <= 1'b0;
    end else begin
      for (int k = 0; k < N_OBST; k++) begin
        if (wr_ok && (wr_idx_i == IDX_W'(k))) shadow_q[k] <= wr_slot;
        // Copies the pre-write shadow value: a same-cycle write is not part of this commit.
        if (do_commit) active_q[k] <= shadow_q[k];
      end
      pending_q    <= pending_d;
      vblnk_prev_q <= bg_in_vblnk_i;
    end
  end

  assign commit_pending_o = pending_q;

  // ---------------------------------------------------------------------------------------
  // Stage 1: per-slot hit vectors, frame hit, blank flag, timing
  // ---------------------------------------------------------------------------------------
  logic [11:0]       h12, v12;
  logic [N_OBST-1:0] outline_d, outline_q;
  logic              frame_d, frame_q;
  logic              blank_q;
  logic [10:0]       hcount_q, vcount_q;
  logic              hsync_q, vsync_q, hblnk_q, vblnk_q;

  assign h12 = {1'b0, bg_in_hcount_i};
  assign v12 = {1'b0, bg_in_vcount_i};

  always_comb begin
    outline_d = '0;
    for (int k = 0; k < N_OBST; k++) begin
      outline_d[k] = slot_outer(active_q[k], h12, v12) && !slot_inner(active_q[k], h12, v12);
    end
  end

  assign frame_d = (h12 < FrameT) || (h12 >= HorLim) || (v12 < FrameT) || (v12 >= VerLim);

`ifdef TERRAIN_FILL_EN
  logic [N_OBST-1:0] interior_d, interior_q;

  always_comb begin
    interior_d = '0;
    for (int k = 0; k < N_OBST; k++) begin
      interior_d[k] = slot_outer(active_q[k], h12, v12) && slot_inner(active_q[k], h12, v12);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) interior_q <= '0;
    else      interior_q <= interior_d;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outline_q <= '0;
      frame_q   <= 1'b0;
      blank_q   <= 1'b0;
      hcount_q  <= '0;
      vcount_q  <= '0;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      hblnk_q   <= 1'b0;
      vblnk_q   <= 1'b0;
    end else begin
      outline_q <= outline_d;
      frame_q   <= frame_d;
      blank_q   <= bg_in_hblnk_i || bg_in_vblnk_i;
      hcount_q  <= bg_in_hcount_i;
      vcount_q  <= bg_in_vcount_i;
      hsync_q   <= bg_in_hsync_i;
      vsync_q   <= bg_in_vsync_i;
      hblnk_q   <= bg_in_hblnk_i;
      vblnk_q   <= bg_in_vblnk_i;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Stage 2: reduce, select colour, register output
  // ---------------------------------------------------------------------------------------
  logic [11:0] rgb_d;

  always_comb begin
    rgb_d = BG_RGB;
    if (blank_q) begin
      rgb_d = 12'h000;
    end else if (frame_q || (|outline_q)) begin
      rgb_d = WALL_RGB;
`ifdef TERRAIN_FILL_EN
    end else if (|interior_q) begin
      rgb_d = FILL_RGB;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bg_out_hcount_o <= '0;
      bg_out_vcount_o <= '0;
      bg_out_hsync_o  <= 1'b0;
      bg_out_vsync_o  <= 1'b0;
      bg_out_hblnk_o  <= 1'b0;
      bg_out_vblnk_o  <= 1'b0;
      bg_out_rgb_o    <= '0;
    end else begin
      bg_out_hcount_o <= hcount_q;
      bg_out_vcount_o <= vcount_q;
      bg_out_hsync_o  <= hsync_q;
      bg_out_vsync_o  <= vsync_q;
      bg_out_hblnk_o  <= hblnk_q;
      bg_out_vblnk_o  <= vblnk_q;
      bg_out_rgb_o    <= rgb_d;
    end
  end

endmodule

// File: tb/tb_draw_terrain.sv
// Self-checking bench for draw_terrain: directed steps from the test plan, then randomized
// pixels, writes, commit requests and vblank edges, all compared every cycle against a
// table-based reference model that follows the rendering and commit rules directly.
module tb_draw_terrain;

  localparam int HP = 320;
  localparam int VP = 240;
  localparam int T  = 5;
  localparam int FT = 1;
  localparam int NO = 16;
  localparam logic [11:0] WALL = 12'h00F;
  localparam logic [11:0] BG   = 12'h000;
`ifdef TERRAIN_FILL_EN
  localparam logic [11:0] INNER = 12'h004;
`else
  localparam logic [11:0] INNER = 12'h000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hc = '0, vc = '0;
  logic        hs = 1'b0, vs = 1'b0, hb = 1'b0, vb = 1'b0;
  logic        wr_en = 1'b0, wr_valid = 1'b0, creq = 1'b0;
  logic [5:0]  wr_idx = '0;
  logic [10:0] wx1 = '0, wy1 = '0, wx2 = '0, wy2 = '0;
  logic [10:0] o_hc, o_vc;
  logic        o_hs, o_vs, o_hb, o_vb, pend;
  logic [11:0] o_rgb;

  draw_terrain #(
    .HOR_PIXELS(HP),
    .VER_PIXELS(VP)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bg_in_hcount_i   (hc),
    .bg_in_vcount_i   (vc),
    .bg_in_hsync_i    (hs),
    .bg_in_vsync_i    (vs),
    .bg_in_hblnk_i    (hb),
    .bg_in_vblnk_i    (vb),
    .bg_out_hcount_o  (o_hc),
    .bg_out_vcount_o  (o_vc),
    .bg_out_hsync_o   (o_hs),
    .bg_out_vsync_o   (o_vs),
    .bg_out_hblnk_o   (o_hb),
    .bg_out_vblnk_o   (o_vb),
    .bg_out_rgb_o     (o_rgb),
    .wr_en_i          (wr_en),
    .wr_idx_i         (wr_idx),
    .wr_valid_i       (wr_valid),
    .wr_x1_i          (wx1),
    .wr_y1_i          (wy1),
    .wr_x2_i          (wx2),
    .wr_y2_i          (wy2),
    .commit_req_i     (creq),
    .commit_pending_o (pend)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int   sh_v [NO], sh_x1 [NO], sh_y1 [NO], sh_x2 [NO], sh_y2 [NO];
  int   ac_v [NO], ac_x1 [NO], ac_y1 [NO], ac_x2 [NO], ac_y2 [NO];
  bit   m_pend, m_prev;
  logic [37:0] exp_s1, exp_s2;

  function automatic void model_clear();
    for (int k = 0; k < NO; k++) begin
      sh_v[k] = 0; sh_x1[k] = 0; sh_y1[k] = 0; sh_x2[k] = 0; sh_y2[k] = 0;
      ac_v[k] = 0; ac_x1[k] = 0; ac_y1[k] = 0; ac_x2[k] = 0; ac_y2[k] = 0;
    end
    m_pend = 0;
    m_prev = 0;
    exp_s1 = '0;
    exp_s2 = '0;
  endfunction

  function automatic logic [11:0] ref_rgb(int h, int v, bit hbl, bit vbl);
    bit wall, fill, outer, inner;
    wall = 0;
    fill = 0;
    if (hbl || vbl) return 12'h000;
    if (h < FT || h >= HP - FT || v < FT || v >= VP - FT) wall = 1;
    for (int k = 0; k < NO; k++) begin
      outer = (ac_v[k] != 0) && ac_x1[k] <= h && h <= ac_x2[k] && ac_y1[k] <= v && v <= ac_y2[k];
      inner = ac_x1[k] + T <= h && h + T <= ac_x2[k] && ac_y1[k] + T <= v && v + T <= ac_y2[k];
      if (outer && !inner) wall = 1;
      if (outer && inner) fill = 1;
    end
    if (wall) return WALL;
    if (fill) return INNER;
    return BG;
  endfunction

  // One clock: update the model with the inputs currently driven, then compare outputs.
  task automatic tick();
    logic [37:0] cur;
    bit do_commit, wr_ok;
    int i;
    cur = {hc, vc, hs, vs, hb, vb, ref_rgb(int'(hc), int'(vc), hb, vb)};
    do_commit = vb && !m_prev && m_pend;
    wr_ok = wr_en && (wr_idx < NO);
    if (do_commit) begin
      for (int k = 0; k < NO; k++) begin
        ac_v[k] = sh_v[k]; ac_x1[k] = sh_x1[k]; ac_y1[k] = sh_y1[k];
        ac_x2[k] = sh_x2[k]; ac_y2[k] = sh_y2[k];
      end
    end
    if (wr_ok) begin
      i = int'(wr_idx);
      sh_v[i] = int'(wr_valid); sh_x1[i] = int'(wx1); sh_y1[i] = int'(wy1);
      sh_x2[i] = int'(wx2); sh_y2[i] = int'(wy2);
    end
    m_pend = do_commit ? (creq || wr_ok) : (m_pend || creq);
    m_prev = vb;
    exp_s2 = exp_s1;
    exp_s1 = cur;
    @(posedge clk);
    #1;
    checks++;
    assert ({o_hc, o_vc, o_hs, o_vs, o_hb, o_vb, o_rgb} === exp_s2) else begin
      errors++;
      $error("FAIL out got %h exp %h", {o_hc, o_vc, o_hs, o_vs, o_hb, o_vb, o_rgb}, exp_s2);
    end
    checks++;
    assert (pend === m_pend) else begin
      errors++;
      $error("FAIL pending got %b exp %b", pend, m_pend);
    end
  endtask

  task automatic drive(input int h, input int v, input bit hbl, input bit vbl);
    hc = 11'(h);
    vc = 11'(v);
    hs = 1'($urandom_range(0, 1));
    vs = 1'($urandom_range(0, 1));
    hb = hbl;
    vb = vbl;
  endtask

  // Drives a pixel, flushes it through the pipeline and checks its colour directly.
  task automatic probe(input int h, input int v, input bit hbl, input bit vbl,
                       input logic [11:0] exp, input string tag);
    drive(h, v, hbl, vbl);
    tick();
    drive(10, 10, 0, 0);
    tick();
    checks++;
    assert (o_rgb === exp && o_hc === 11'(h)) else begin
      errors++;
      $error("FAIL %s rgb=%h hc=%0d exp rgb=%h hc=%0d", tag, o_rgb, o_hc, exp, h);
    end
  endtask

  task automatic write(input int idx, input bit val, input int x1, input int y1,
                       input int x2, input int y2);
    wr_en = 1'b1; wr_idx = 6'(idx); wr_valid = val;
    wx1 = 11'(x1); wy1 = 11'(y1); wx2 = 11'(x2); wy2 = 11'(y2);
    drive(5, 5, 0, 0);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic request_commit();
    creq = 1'b1;
    drive(30, 30, 0, 0);
    tick();
    creq = 1'b0;
  endtask

  task automatic vblank_pulse();
    drive(0, 200, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(i, VP, 1, 1);
      tick();
    end
  endtask

  initial begin
    int vstate, h, v, x1, y1;
    model_clear();
    // Reset from power-up
    #2 rst = 1'b0;
    #1;
    checks++;
    assert (o_rgb === 12'h000 && o_hc === 11'd0 && pend === 1'b0) else begin
      errors++;
      $error("FAIL reset rgb=%h hc=%0d pend=%b exp 000/0/0", o_rgb, o_hc, pend);
    end
    @(posedge clk);
    #1 rst = 1'b1;

    // Frame only after reset
    probe(0, 50, 0, 0, WALL, "frame_h0");
    probe(HP - 1, 50, 0, 0, WALL, "frame_hmax");
    probe(50, 0, 0, 0, WALL, "frame_v0");
    probe(50, VP - 1, 0, 0, WALL, "frame_vmax");
    probe(160, 120, 0, 0, BG, "bg_centre");
    probe(1, 1, 0, 0, BG, "bg_corner_in");
    probe(50, 50, 1, 0, 12'h000, "hblank");

    // Slot 3 obstacle
    write(3, 1, 100, 100, 199, 149);
    probe(102, 120, 0, 0, BG, "slot3_before_commit");
    request_commit();
    checks++;
    assert (pend === 1'b1) else begin
      errors++;
      $error("FAIL pend_after_req got %b exp 1", pend);
    end
    vblank_pulse();
    checks++;
    assert (pend === 1'b0) else begin
      errors++;
      $error("FAIL pend_after_commit got %b exp 0", pend);
    end
    probe(102, 120, 0, 0, WALL, "slot3_outline");
    probe(150, 120, 0, 0, INNER, "slot3_interior");
    probe(200, 120, 0, 0, BG, "slot3_right_out");
    probe(99, 120, 0, 0, BG, "slot3_left_out");

    // Write without commit: nothing changes across a vblank
    write(5, 1, 20, 20, 40, 40);
    probe(30, 20, 0, 0, BG, "nocommit_same_frame");
    vblank_pulse();
    probe(30, 20, 0, 0, BG, "nocommit_next_frame");
    request_commit();
    probe(30, 20, 0, 0, BG, "pending_frame");
    vblank_pulse();
    probe(20, 30, 0, 0, WALL, "slot5_after_commit");

    // Write on the commit edge
    request_commit();
    drive(0, 200, 0, 0);
    tick();
    wr_en = 1'b1; wr_idx = 6'd6; wr_valid = 1'b1;
    wx1 = 11'd200; wy1 = 11'd200; wx2 = 11'd220; wy2 = 11'd220;
    drive(0, VP, 1, 1);
    tick();
    wr_en = 1'b0;
    checks++;
    assert (pend === 1'b1) else begin
      errors++;
      $error("FAIL pend_edge_write got %b exp 1", pend);
    end
    drive(1, VP, 1, 1);
    tick();
    probe(200, 210, 0, 0, BG, "edge_write_absent");
    vblank_pulse();
    probe(200, 210, 0, 0, WALL, "edge_write_next");

    // Degenerate slots and out-of-range index
    write(7, 1, 50, 50, 55, 55);
    write(8, 1, 60, 60, 40, 70);
    write(16, 1, 0, 0, HP - 1, VP - 1);
    request_commit();
    vblank_pulse();
    probe(52, 52, 0, 0, WALL, "narrow_solid");
    probe(50, 65, 0, 0, BG, "reversed_never");
    probe(260, 60, 0, 0, BG, "idx_out_of_range");

    // Asynchronous reset with slot 3 on screen
    probe(102, 120, 0, 0, WALL, "slot3_before_reset");
    drive(102, 120, 0, 0);
    tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    assert (o_rgb === 12'h000 && o_hc === 11'd0 && pend === 1'b0) else begin
      errors++;
      $error("FAIL async_reset rgb=%h hc=%0d pend=%b exp 000/0/0", o_rgb, o_hc, pend);
    end
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    probe(102, 120, 0, 0, BG, "slot3_gone");
    probe(0, 120, 0, 0, WALL, "frame_after_reset");

    // Randomized traffic against the model
    vstate = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) vstate = 1 - vstate;
      h = $urandom_range(0, HP + 9);
      v = $urandom_range(0, VP + 9);
      drive(h, v, (h >= HP) || ($urandom_range(0, 19) == 0), vstate != 0);
      creq = ($urandom_range(0, 29) == 0);
      wr_en = ($urandom_range(0, 9) == 0);
      if (wr_en) begin
        x1 = $urandom_range(0, 300);
        y1 = $urandom_range(0, 220);
        wr_idx = 6'($urandom_range(0, NO + 2));
        wr_valid = ($urandom_range(0, 3) != 0);
        wx1 = 11'(x1);
        wy1 = 11'(y1);
        wx2 = 11'(x1 + $urandom_range(0, 70) - 5);
        wy2 = 11'(y1 + $urandom_range(0, 50) - 5);
      end
      tick();
    end
    creq = 1'b0;
    wr_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
